if_byte_fetch: RTL
==================

Name: if_byte_fetch

Overview:
- Instruction-fetch stage directly upstream of the decode stage: owns the PC and assembles each 32-bit instruction from four byte reads on the shared 8-bit memory port.
- Delivers {pc, inst} to the IF/ID register with a one-cycle valid pulse.
- Redirects on the taken-branch/jump target produced by decode and discards any wrong-path bytes already in flight.

Parameters:
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall_in  in  1  ctrl stall for IF/ID; blocks delivery and branch acceptance.
- branch_flag_in  in  1  decode: redirect request.
- branch_target_in  in  32  decode: redirect target PC.
- mem_grant_in  in  1  port arbiter accepted this cycle's request.
- mem_data_in  in  8  read byte, valid the cycle after a granted request.
- mem_req_out  out  1  byte read request.
- mem_addr_out  out  32  byte address of request.
- pc_out  out  32  PC of delivered instruction (registered).
- inst_out  out  32  delivered instruction (registered).
- inst_valid_out  out  1  one-cycle pulse: IF/ID loads pc_out/inst_out.
- stallreq_out  out  1  to ctrl: no instruction delivered this cycle.

Behaviour:
- State: pc[31:0], issue_cnt[2:0] (0..4 requests granted), recv_cnt[2:0] (0..3 bytes captured), pending (one granted request awaiting data), byte buffer[23:0], state in {FETCH, HOLD}.
- Reset (async, any time, including mid-fetch): pc=RESET_PC, counters=0, pending=0, state=FETCH; pc_out=0, inst_out=0, inst_valid_out=0. While rst=1: mem_req_out=0, mem_addr_out=0, stallreq_out=0.
- Outputs mem_req_out, mem_addr_out, stallreq_out are combinational:
  - mem_req_out = (state==FETCH) && issue_cnt<4.
  - mem_addr_out = pc + issue_cnt (32-bit wrap).
  - stallreq_out = !inst_valid_out.
- FETCH:
  - Granted request: issue_cnt+1, pending=1.
  - Non-granted request: address held, no state change; requests are issued back-to-back.
  - When pending at an edge: capture mem_data_in into byte lane recv_cnt (little-endian: byte k -> inst[8k+7:8k]), recv_cnt+1.
- Completion edge (capture of byte 3):
  - inst_out = {mem_data_in, buffer}, pc_out = pc.
  - If stall_in=0: inst_valid_out=1 next cycle, pc=pc+4, counters cleared. The next fetch's first request is issued in the same cycle the pulse is high.
  - If stall_in=1: enter HOLD, no requests.
- HOLD: wait for stall_in=0. On that edge: inst_valid_out=1, pc=pc+4, counters cleared, go to FETCH.
- inst_valid_out is high for exactly one cycle per delivered instruction.
- Latency: with continuous grant and no stall, the first pulse comes in cycle 5 after reset release (cycle 0 = first request). Steady-state throughput is 1 instruction per 5 cycles.
- Redirect (branch_flag_in=1 && stall_in=0 at an edge, either state):
  - pc=branch_target_in, issue_cnt=0, recv_cnt=0, pending=0, state=FETCH.
  - The byte returning the next cycle for an already-granted request is ignored.
  - The partially assembled or held instruction is never delivered.
- Redirect coinciding with a completion edge or HOLD release: redirect wins, no pulse.
- branch_flag_in while stall_in=1 is ignored (decode operands not final).
- An instruction already pulsed when the redirect arrives is flushed from IF/ID by ctrl, not by this block.
- branch_target_in is used unaligned as given; bits [1:0] are not forced.

Test Plan:
- Reset release, grant always 1, memory bytes 0x00..0x07 = 13 05 50 00 93 05 60 00 → mem_addr_out 0,1,2,3 in cycles 0-3. Cycle 5: inst_valid_out=1, pc_out=0, inst_out=0x00500513. Cycle 10: pulse, pc_out=4, inst_out=0x00600593.
- mem_grant_in=0 in cycles 1-2 → mem_addr_out held at 1 for cycles 1-3; pulse delayed to cycle 7 with the same inst_out.
- stall_in=1 from cycle 3 to cycle 8 → no pulse and no mem_req_out in cycles 5-8. stall_in=0 in cycle 9 → pulse in cycle 10, byte-0 request for pc=4 also in cycle 10.
- branch_flag_in=1, target 0x100, stall_in=0, at edge ending cycle 2 → in-flight byte ignored; requests to 0x100..0x103 start cycle 3; pulse with pc_out=0x100 in cycle 8; no pulse for pc=0.
- branch_flag_in=1 with stall_in=1 → ignored, fetch unaffected. Branch at the completion edge → no pulse, refetch from the target.
- rst asserted mid-fetch (after 2 bytes) → all outputs 0 immediately. On release, fetch restarts at RESET_PC with no stale bytes merged.

Source files
------------

// File: rtl/if_byte_fetch.sv
// -----------------------------------------------------------------------------
// if_byte_fetch
//
// Instruction-fetch stage that sits directly in front of decode. It owns the
// program counter and builds each 32-bit instruction from four byte reads on
// the shared 8-bit memory port. Bytes are requested back-to-back, one per
// granted cycle, and each byte comes back one cycle after its grant. When all
// four bytes are in, {pc, inst} goes to the IF/ID register with a single-cycle
// valid pulse.
//
// A taken branch/jump from decode redirects the PC. Any byte still in flight
// for the old path is dropped, and a partly built or held instruction is
// never delivered.
//
// Ports
//   clk               clock, all state updates on the rising edge
//   rst               asynchronous, active-high reset
//   stall_in          IF/ID stall from ctrl; blocks delivery and redirects
//   branch_flag_in    redirect request from decode
//   branch_target_in  redirect target PC (used as given, may be unaligned)
//   mem_grant_in      arbiter accepted this cycle's byte request
//   mem_data_in       read byte, valid the cycle after a granted request
//   mem_req_out       byte read request (combinational)
//   mem_addr_out      byte address of the request (combinational)
//   pc_out            PC of the delivered instruction (registered)
//   inst_out          delivered instruction (registered)
//   inst_valid_out    one-cycle pulse: IF/ID loads pc_out/inst_out
//   stallreq_out      to ctrl: no instruction delivered this cycle
// -----------------------------------------------------------------------------
module if_byte_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        branch_flag_in,
    input  logic [31:0] branch_target_in,
    input  logic        mem_grant_in,
    input  logic [7:0]  mem_data_in,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        inst_valid_out,
    output logic        stallreq_out
);

    // FETCH: issue byte requests and collect bytes.
    // HOLD : a complete instruction is waiting for the IF/ID stall to clear.
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [2:0]  issue_cnt;   // requests granted for this instruction, 0..4
    logic [2:0]  recv_cnt;    // bytes captured for this instruction, 0..3
    logic        pending;     // a granted request's byte arrives this cycle
    logic [23:0] buffer;      // bytes 0..2, little-endian lanes

    logic        req;         // request before reset gating
    logic        granted;
    logic        redirect;
    logic        completing;  // byte 3 is arriving at this edge
    logic        capture;     // bytes 0..2 are written into the buffer

    // NOTE: every signal written here is assigned on every path through the
    // block, so it stays pure combinational logic and never infers a latch.
    always_comb begin
        req          = (state == FETCH) && (issue_cnt < 3'd4);
        mem_req_out  = req && !rst;
        mem_addr_out = rst ? 32'h0 : pc + {29'b0, issue_cnt};
        stallreq_out = !rst && !inst_valid_out;
    end

    assign granted  = req && mem_grant_in;

    // Decode operands are not final while stalled, so a branch seen under a
    // stall is not acted on.
    assign redirect = branch_flag_in && !stall_in;

    assign completing = (state == FETCH) && pending && (recv_cnt == 3'd3);
    assign capture    = (state == FETCH) && pending && (recv_cnt < 3'd3) && !redirect;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values no matter how the statements in
    // this block are ordered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            issue_cnt      <= 3'd0;
            recv_cnt       <= 3'd0;
            pending        <= 1'b0;
            pc_out         <= 32'h0;
            inst_out       <= 32'h0;
            inst_valid_out <= 1'b0;
        end else begin
            inst_valid_out <= 1'b0;

            if (redirect) begin
                // The redirect beats completion and HOLD release. Clearing
                // pending drops the byte that returns next cycle for a
                // request granted on the old path.
                state     <= FETCH;
                pc        <= branch_target_in;
                issue_cnt <= 3'd0;
                recv_cnt  <= 3'd0;
                pending   <= 1'b0;
            end else begin
                case (state)
                    FETCH: begin
                        if (completing) begin
                            inst_out <= {mem_data_in, buffer};
                            pc_out   <= pc;
                            pending  <= 1'b0;
                            if (stall_in) begin
                                state <= HOLD;
                            end else begin
                                // The next fetch's first request goes out
                                // in the same cycle the pulse is high.
                                inst_valid_out <= 1'b1;
                                pc             <= pc + 32'd4;
                                issue_cnt      <= 3'd0;
                                recv_cnt       <= 3'd0;
                            end
                        end else begin
                            if (granted) begin
                                issue_cnt <= issue_cnt + 3'd1;
                            end
                            pending <= granted;
                            if (pending) begin
                                recv_cnt <= recv_cnt + 3'd1;
                            end
                        end
                    end

                    HOLD: begin
                        if (!stall_in) begin
                            state          <= FETCH;
                            inst_valid_out <= 1'b1;
                            pc             <= pc + 32'd4;
                            issue_cnt      <= 3'd0;
                            recv_cnt       <= 3'd0;
                            pending        <= 1'b0;
                        end
                    end

                    default: begin
                        state <= FETCH;
                    end
                endcase
            end
        end
    end

    // NOTE: the byte buffer is pure datapath and has no reset. recv_cnt
    // decides which lanes hold valid bytes, so old contents are overwritten
    // before they are used and are never merged into a new instruction.
    always_ff @(posedge clk) begin
        if (capture) begin
            case (recv_cnt)
                3'd0:    buffer[7:0]   <= mem_data_in;
                3'd1:    buffer[15:8]  <= mem_data_in;
                3'd2:    buffer[23:16] <= mem_data_in;
                default: buffer        <= buffer;
            endcase
        end
    end

    // A delivery is always followed by at least one full byte fetch, so two
    // pulses can never be adjacent.
    a_single_pulse: assert property (
        @(posedge clk) disable iff (rst) inst_valid_out |=> !inst_valid_out
    );

    // Every captured byte belongs to a granted request.
    a_recv_le_issue: assert property (
        @(posedge clk) disable iff (rst) recv_cnt <= issue_cnt
    );

    // A byte can only be outstanding after at least one grant.
    a_pending_has_issue: assert property (
        @(posedge clk) disable iff (rst) pending |-> (issue_cnt != 3'd0)
    );

endmodule
